// File: rtl/alu_seq.sv
// Registered 6502-style ALU with valid/ready handshakes on both sides,
// a WIDTH-generic binary datapath and nibble-serial decimal ADD/SUB.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake; in_ready is high only in IDLE
//   alu_op              ADD SUB AND OR XOR INC DEC ASL LSR ROL ROR PASS
//   reg1, reg2          operands A and B
//   carry_in            C in (for SUB, 1 = no borrow)
//   decimal_in          6502 D flag, honoured by ADD/SUB only
//   out_valid/out_ready result handshake; result/flags held until taken
//   result              registered result
//   flags               registered {N,V,Z,C}
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    input  logic             carry_in,
    input  logic             decimal_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int DIGITS = WIDTH / 4;
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int MSB    = WIDTH - 1;

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_INC  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_DEC  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_ASL  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_LSR  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_ROL  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_ROR  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_PASS = OP_W'(11);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_BCD,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [OP_W-1:0]  r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;
    logic             r_dec;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;
    logic [CW-1:0]    r_cnt;
    logic             r_dc;
    logic             r_v;

    logic             w_accept;
    logic             w_is_dec;
    logic             w_last;

    logic [WIDTH-1:0] w_bb;
    logic [WIDTH:0]   w_sum;
    logic             w_add_v;
    logic [WIDTH-1:0] w_bin_r;
    logic             w_bin_c;
    logic             w_bin_v;

    logic [CW+1:0]    w_shamt;
    logic [3:0]       w_an;
    logic [3:0]       w_bn;
    logic [4:0]       w_s5;
    logic [5:0]       w_d6;
    logic [3:0]       w_nib;
    logic             w_dc_nx;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_bcd_res;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign flags     = r_flags;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_is_dec = r_dec && ((r_op == OP_ADD) || (r_op == OP_SUB));
    assign w_last   = (r_cnt == CW'(DIGITS - 1));

    // Binary datapath; SUB reuses the adder with B inverted.
    always_comb begin
        w_bb    = (r_op == OP_SUB) ? ~r_b : r_b;
        w_sum   = {1'b0, r_a} + {1'b0, w_bb} + {{WIDTH{1'b0}}, r_cin};
        w_add_v = ~(r_a[MSB] ^ w_bb[MSB]) & (r_a[MSB] ^ w_sum[MSB]);
        w_bin_r = '0;
        w_bin_c = 1'b0;
        w_bin_v = 1'b0;
        case (r_op)
            OP_ADD, OP_SUB: begin
                w_bin_r = w_sum[MSB:0];
                w_bin_c = w_sum[WIDTH];
                w_bin_v = w_add_v;
            end
            OP_AND:  w_bin_r = r_a & r_b;
            OP_OR:   w_bin_r = r_a | r_b;
            OP_XOR:  w_bin_r = r_a ^ r_b;
            OP_INC:  w_bin_r = r_a + WIDTH'(1);
            OP_DEC:  w_bin_r = r_a - WIDTH'(1);
            OP_ASL: begin
                w_bin_r = {r_a[MSB-1:0], 1'b0};
                w_bin_c = r_a[MSB];
            end
            OP_LSR: begin
                w_bin_r = {1'b0, r_a[MSB:1]};
                w_bin_c = r_a[0];
            end
            OP_ROL: begin
                w_bin_r = {r_a[MSB-1:0], r_cin};
                w_bin_c = r_a[MSB];
            end
            OP_ROR: begin
                w_bin_r = {r_cin, r_a[MSB:1]};
                w_bin_c = r_a[0];
            end
            OP_PASS: w_bin_r = r_b;
            default: ;
        endcase
    end

    // One decimal digit per cycle; the digit lands in place in r_result.
    always_comb begin
        w_shamt = {r_cnt, 2'b00};
        w_an    = 4'(r_a >> w_shamt);
        w_bn    = 4'(r_b >> w_shamt);
        w_s5    = {1'b0, w_an} + {1'b0, w_bn} + {4'b0, r_dc};
        w_d6    = {2'b0, w_an} - {2'b0, w_bn} - {5'b0, ~r_dc};
        w_nib   = w_s5[3:0];
        w_dc_nx = 1'b0;
        if (r_op == OP_SUB) begin
            // r_dc is "no borrow"; a negative digit borrows from the next.
            if (w_d6[5]) begin
                w_nib   = w_d6[3:0] + 4'd10;
                w_dc_nx = 1'b0;
            end else begin
                w_nib   = w_d6[3:0];
                w_dc_nx = 1'b1;
            end
        end else begin
            if (w_s5 > 5'd9) begin
                w_nib   = w_s5[3:0] + 4'd6;
                w_dc_nx = 1'b1;
            end else begin
                w_nib   = w_s5[3:0];
                w_dc_nx = 1'b0;
            end
        end
        w_mask    = WIDTH'(4'hF) << w_shamt;
        w_bcd_res = (r_result & ~w_mask) | (WIDTH'(w_nib) << w_shamt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (in_valid) w_next = S_EXEC;
            S_EXEC:  w_next = w_is_dec ? S_BCD : S_DONE;
            S_BCD:   if (w_last) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cin    <= 1'b0;
            r_dec    <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
            r_cnt    <= '0;
            r_dc     <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= alu_op;
                r_a   <= reg1;
                r_b   <= reg2;
                r_cin <= carry_in;
                r_dec <= decimal_in;
                r_cnt <= '0;
            end
            if (r_state == S_EXEC) begin
                r_result <= w_bin_r;
                r_v      <= w_bin_v;
                r_dc     <= r_cin;
                r_cnt    <= '0;
                if (!w_is_dec) begin
                    r_flags <= {w_bin_r[MSB], w_bin_v,
                                (w_bin_r == '0), w_bin_c};
                end
            end
            if (r_state == S_BCD) begin
                r_result <= w_bcd_res;
                r_dc     <= w_dc_nx;
                if (w_last) begin
                    r_cnt   <= '0;
                    // V stays as the binary adder produced it.
                    r_flags <= {w_bcd_res[MSB], r_v,
                                (w_bcd_res == '0), w_dc_nx};
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: doc/alu_seq.md
Name:
alu_seq

Overview:
- Parametrised, registered successor to the combinational 6502 ALU.
- Adds valid/ready handshakes on input and output, WIDTH-generic datapath, and 6502 decimal (BCD) mode for ADD/SUB.
- BCD correction is performed nibble-serially over multiple cycles.
- Sits between the decode/execute control and the register file; the control FSM stalls on in_ready/out_valid.

Parameters:
- WIDTH, 8, datapath width in bits; must be a multiple of 4 and at least 4.
- OP_W, 5, alu_op width.
- DIGITS, WIDTH/4, derived (localparam): number of BCD nibbles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/op valid.
- in_ready  output  1  block can accept; high only in IDLE.
- alu_op  input  OP_W  op code: ADD=0 SUB=1 AND=2 OR=3 XOR=4 INC=5 DEC=6 ASL=7 LSR=8 ROL=9 ROR=10 PASS=11; other codes behave as "result 0, C=0, V=0".
- reg1  input  WIDTH  operand A.
- reg2  input  WIDTH  operand B.
- carry_in  input  1  C in; for SUB, 1 = no borrow.
- decimal_in  input  1  6502 D flag; affects ADD/SUB only.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- flags  output  4  {N,V,Z,C}, registered.

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; result=0; flags=0; nibble counter=0. rst has priority over all other inputs in every state; asserting it mid-operation discards the operation with no output.
- Accept: in IDLE, in_valid=1 latches alu_op, reg1, reg2, carry_in and decimal_in. in_ready drops the next cycle. Inputs are ignored outside IDLE.
- IDLE -> EXEC on accept.
- EXEC:
  - Computes the binary result, C and V exactly as the 8-bit ALU, generalised to WIDTH (MSB replaces bit 7).
  - ADD: {C,R}=A+B+cin; V=~(A^B)[msb] & (A^R)[msb].
  - SUB: {C,R}=A+~B+cin; V computed the same way with ~B in place of B.
  - INC/DEC: wrap modulo 2^WIDTH; C=0, V=0.
  - Shifts/rotates: C = bit shifted out; ROL inserts cin at bit 0; ROR inserts cin at the MSB.
  - PASS: R=B.
  - If decimal_in=1 and op is ADD or SUB: go to BCD with counter=0 and digit carry=cin. Otherwise go to DONE.
- BCD: one nibble per cycle, LSB nibble first; counter runs 0..DIGITS-1.
  - ADD: s=a+b+dc (5-bit); if s>9 then nibble=(s+6)[3:0], dc=1; else nibble=s[3:0], dc=0.
  - SUB: d=a-b-(~dc); if d<0 then nibble=(d+10)[3:0], dc=0 (borrow); else nibble=d[3:0], dc=1.
  - Non-BCD digits follow the same arithmetic mod 16; no error is flagged.
  - After nibble DIGITS-1: C=dc, go to DONE. V is retained from the EXEC binary computation.
- Flags: N=result[msb]; Z=(result==0), both taken from the final result (decimal result in BCD mode).
- Latency from the accept edge to out_valid high:
  - Binary ops: 2 cycles (EXEC, then DONE).
  - Decimal ADD/SUB: 2+DIGITS cycles.
- DONE: out_valid=1; result and flags are held stable until out_ready=1. On the handshake edge: out_valid=0, go to IDLE (in_ready=1 the following cycle). No bypass: back-to-back throughput is one op per (latency+1) cycles.
- out_ready is a don't-care outside DONE. in_valid held during DONE does not cause an accept.

Test Plan:
- WIDTH=8, ADD, A=0x7F, B=0x01, cin=0, D=0 -> result 0x80, flags N=1 V=1 Z=0 C=0; out_valid exactly 2 cycles after accept.
- WIDTH=8, ADD, A=0x58, B=0x46, cin=1, D=1 -> result 0x05, C=1, Z=0, N=0; out_valid at accept+4.
- WIDTH=8, SUB, A=0x40, B=0x13, cin=1, D=1 -> result 0x27, C=1. Then A=0x10, B=0x20, cin=1, D=1 -> result 0x90, C=0.
- WIDTH=16, ROR, A=0x0001, cin=1 -> result 0x8000, C=1, N=1. Also ASL, A=0x8000 -> result 0x0000, Z=1, C=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/flags stable and in_ready=0 throughout; a new in_valid is not accepted until the cycle after the out handshake.
- Reset mid-BCD (rst on counter=1, WIDTH=16) -> next cycle IDLE, out_valid=0, result=0, flags=0; a subsequent op completes normally.
